// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the IF/DM memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    // Wide all-ones mask; the arbiter slices it down to its byte-enable width.
    localparam int BE_MAX_WIDTH = 128;
    localparam logic [BE_MAX_WIDTH-1:0] BE_FULL = '1;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - DM-first arbiter with IF starvation guard over one variable-latency memory
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_ready,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    dm_req,
    input  logic                    dm_we,
    input  logic [ADDR_WIDTH-1:0]   dm_addr,
    input  logic [DATA_WIDTH-1:0]   dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] dm_be,
    output logic                    dm_ready,
    output logic [DATA_WIDTH-1:0]   dm_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state;
    state_t           state_next;
    owner_t           owner;
    logic [CNT_W-1:0] starve_cnt;
    logic             grant_dm;
    logic             grant_if;

    always_comb begin
        grant_dm   = dm_req && (!if_req || (starve_cnt < LIMIT));
        grant_if   = if_req && !grant_dm;
        state_next = state;
        case (state)
            IDLE:    if (grant_dm || grant_if) state_next = BUSY;
            BUSY:    if (mem_ack) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Decoded straight from the state register so reset clears them without waiting for a clock.
    assign mem_req  = (state == BUSY);
    assign if_ready = (state == DONE) && (owner == OWN_IF);
    assign dm_ready = (state == DONE) && (owner == OWN_DM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= OWN_IF;
            starve_cnt <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            if (state == IDLE) begin
                if (grant_dm) begin
                    owner      <= OWN_DM;
                    mem_we     <= dm_we;
                    mem_addr   <= dm_addr;
                    mem_wdata  <= dm_wdata;
                    mem_be     <= dm_be;
                    // A DM grant over a waiting IF only happens below LIMIT, so +1 never overshoots.
                    starve_cnt <= if_req ? starve_cnt + CNT_W'(1) : '0;
                end else if (grant_if) begin
                    owner      <= OWN_IF;
                    mem_we     <= 1'b0;
                    mem_addr   <= if_addr;
                    mem_wdata  <= '0;
                    mem_be     <= BE_FULL[BE_W-1:0];
                    starve_cnt <= '0;
                end
            end
            if ((state == BUSY) && mem_ack && !mem_we) begin
                if (owner == OWN_DM) dm_rdata <= mem_rdata;
                else                 if_rdata <= mem_rdata;
            end
        end
    end

endmodule
